// File: rtl/wb_regfile_scoreboard_if.sv
// Decode/writeback-side bundle for wb_regfile_scoreboard.
// master: the pipeline (decode + writeback) driving requests.
// slave:  the register file / scoreboard answering them.
interface wb_regfile_scoreboard_if #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = 2
);
  // writeback port (stage 5)
  logic                 RegWrite;
  logic [IDX_W-1:0]     RegWriteTarget;
  logic [WORD_SIZE-1:0] WriteData;
  // decode read ports (stage 2)
  logic [IDX_W-1:0]     ReadAddr1;
  logic [IDX_W-1:0]     ReadAddr2;
  logic                 ReadUse1;
  logic                 ReadUse2;
  logic [WORD_SIZE-1:0] ReadData1;
  logic [WORD_SIZE-1:0] ReadData2;
  // scoreboard bookkeeping
  logic                 Issue;
  logic [IDX_W-1:0]     IssueTarget;
  logic                 Squash;
  logic [IDX_W-1:0]     SquashTarget;
  logic                 Stall;
  logic                 PendErr;

  modport master (
    output RegWrite, RegWriteTarget, WriteData,
    output ReadAddr1, ReadAddr2, ReadUse1, ReadUse2,
    output Issue, IssueTarget, Squash, SquashTarget,
    input  ReadData1, ReadData2, Stall, PendErr
  );

  modport slave (
    input  RegWrite, RegWriteTarget, WriteData,
    input  ReadAddr1, ReadAddr2, ReadUse1, ReadUse2,
    input  Issue, IssueTarget, Squash, SquashTarget,
    output ReadData1, ReadData2, Stall, PendErr
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Register file with per-register pending-writer scoreboard.
// Two combinational read ports for decode, one write port from writeback,
// and a saturating in-flight counter per register that drives Stall.
// Optional macro WB_BYPASS_EN: same-cycle writeback bypass on both read
// ports, and the last retiring writer no longer marks its register busy.
module wb_regfile_scoreboard #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_REGS    = 4,
  parameter int MAX_PENDING = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_regfile_scoreboard_if.slave bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [WORD_SIZE-1:0] regs_q  [NUM_REGS];
  logic [CNT_W-1:0]     cnt_q   [NUM_REGS];
  logic [CNT_W-1:0]     cnt_d   [NUM_REGS];
  logic                 pend_err_q;
  logic                 pend_err_d;
  logic [NUM_REGS-1:0]  busy;

  // Next pending count per register: net of issue / retire / squash, holding
  // on overflow and clamping to zero on underflow, both flagging an error.
  always_comb begin
    int nxt;
    pend_err_d = pend_err_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      nxt = int'(cnt_q[r]);
      if (bus.Issue && (bus.IssueTarget == IDX_W'(r)))
        nxt = nxt + 1;
      if (bus.RegWrite && (bus.RegWriteTarget == IDX_W'(r)))
        nxt = nxt - 1;
      if (bus.Squash && (bus.SquashTarget == IDX_W'(r)))
        nxt = nxt - 1;
      if (nxt > MAX_PENDING) begin
        cnt_d[r]   = cnt_q[r];
        pend_err_d = 1'b1;
      end else if (nxt < 0) begin
        cnt_d[r]   = '0;
        pend_err_d = 1'b1;
      end else begin
        cnt_d[r]   = CNT_W'(nxt);
      end
    end
  end

  // Storage, counters and sticky error; reset drops every pending update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      pend_err_q <= 1'b0;
    end else begin
      if (bus.RegWrite)
        regs_q[bus.RegWriteTarget] <= bus.WriteData;
      for (int unsigned r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
      pend_err_q <= pend_err_d;
    end
  end

  // Busy map: a register with any in-flight writer is not yet readable.
  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
`ifdef WB_BYPASS_EN
      // Final writer retiring now is forwarded, so it no longer blocks.
      if ((cnt_q[r] == CNT_W'(1)) && bus.RegWrite &&
          (bus.RegWriteTarget == IDX_W'(r)))
        busy[r] = 1'b0;
`endif
    end
  end

  // Read ports and stall decision, all combinational.
  always_comb begin
    bus.ReadData1 = regs_q[bus.ReadAddr1];
    bus.ReadData2 = regs_q[bus.ReadAddr2];
`ifdef WB_BYPASS_EN
    if (bus.RegWrite && (bus.RegWriteTarget == bus.ReadAddr1))
      bus.ReadData1 = bus.WriteData;
    if (bus.RegWrite && (bus.RegWriteTarget == bus.ReadAddr2))
      bus.ReadData2 = bus.WriteData;
`endif
    bus.Stall   = (bus.ReadUse1 && busy[bus.ReadAddr1]) ||
                  (bus.ReadUse2 && busy[bus.ReadAddr2]);
    bus.PendErr = pend_err_q;
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard; expectations follow the
// WB_BYPASS_EN setting of the build.
module tb_wb_regfile_scoreboard;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  wb_regfile_scoreboard_if #(.WORD_SIZE(16), .IDX_W(2)) bus ();

  wb_regfile_scoreboard #(
    .WORD_SIZE  (16),
    .NUM_REGS   (4),
    .MAX_PENDING(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // advance one clock; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWrite = 1'b0; bus.RegWriteTarget = '0; bus.WriteData = '0;
    bus.Issue = 1'b0; bus.IssueTarget = '0;
    bus.Squash = 1'b0; bus.SquashTarget = '0;
  endtask

  task automatic issue(input logic [1:0] t);
    bus.Issue = 1'b1; bus.IssueTarget = t;
    step();
    bus.Issue = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1;
    idle();
    bus.ReadAddr1 = '0; bus.ReadAddr2 = '0;
    bus.ReadUse1 = 1'b0; bus.ReadUse2 = 1'b0;
    step();

    // reset then read
    do_reset();
    bus.ReadAddr1 = 2'd2; bus.ReadUse1 = 1'b1;
    #1;
    chk("rst_rd1", 32'(bus.ReadData1), 32'h0000);
    chk("rst_stall", 32'(bus.Stall), 0);
    chk("rst_err", 32'(bus.PendErr), 0);

    // RAW stall on r1, writeback three cycles after issue
    bus.ReadUse1 = 1'b0;
    issue(2'd1);
    bus.ReadAddr1 = 2'd1; bus.ReadUse1 = 1'b1;
    #1;
    chk("raw_stall", 32'(bus.Stall), 1);
    step();
    step();
    bus.RegWrite = 1'b1; bus.RegWriteTarget = 2'd1; bus.WriteData = 16'hBEEF;
    #1;
`ifdef WB_BYPASS_EN
    chk("raw_wb_stall", 32'(bus.Stall), 0);
    chk("raw_wb_rd1", 32'(bus.ReadData1), 32'hBEEF);
`else
    chk("raw_wb_stall", 32'(bus.Stall), 1);
    chk("raw_wb_rd1", 32'(bus.ReadData1), 32'h0000);
`endif
    step();
    idle();
    #1;
    chk("raw_after_stall", 32'(bus.Stall), 0);
    chk("raw_after_rd1", 32'(bus.ReadData1), 32'hBEEF);
    chk("raw_err", 32'(bus.PendErr), 0);

    // simultaneous issue + retire on r2 with cnt=1
    bus.ReadUse1 = 1'b0;
    issue(2'd2);
    bus.Issue = 1'b1; bus.IssueTarget = 2'd2;
    bus.RegWrite = 1'b1; bus.RegWriteTarget = 2'd2; bus.WriteData = 16'h1234;
    bus.ReadAddr2 = 2'd2; bus.ReadUse2 = 1'b1;
    #1;
`ifdef WB_BYPASS_EN
    chk("sim_cyc_stall", 32'(bus.Stall), 0);
    chk("sim_cyc_rd2", 32'(bus.ReadData2), 32'h1234);
`else
    chk("sim_cyc_stall", 32'(bus.Stall), 1);
    chk("sim_cyc_rd2", 32'(bus.ReadData2), 32'h0000);
`endif
    step();
    idle();
    #1;
    chk("sim_stall", 32'(bus.Stall), 1);
    chk("sim_rd2", 32'(bus.ReadData2), 32'h1234);
    chk("sim_err", 32'(bus.PendErr), 0);
    bus.RegWrite = 1'b1; bus.RegWriteTarget = 2'd2; bus.WriteData = 16'h4321;
    step();
    idle();
    #1;
    chk("sim_drain_stall", 32'(bus.Stall), 0);

    // squash: two issues, one squash, one retire on r3
    bus.ReadUse2 = 1'b0;
    issue(2'd3);
    issue(2'd3);
    bus.Squash = 1'b1; bus.SquashTarget = 2'd3;
    step();
    idle();
    bus.ReadAddr2 = 2'd3; bus.ReadUse2 = 1'b1;
    #1;
    chk("sq_one_left", 32'(bus.Stall), 1);
    bus.RegWrite = 1'b1; bus.RegWriteTarget = 2'd3; bus.WriteData = 16'h5555;
    step();
    idle();
    #1;
    chk("sq_stall", 32'(bus.Stall), 0);
    chk("sq_err", 32'(bus.PendErr), 0);
    chk("sq_rd2", 32'(bus.ReadData2), 32'h5555);

    // ReadUse gating with cnt[r1]=2
    bus.ReadUse2 = 1'b0;
    issue(2'd1);
    issue(2'd1);
    bus.ReadAddr1 = 2'd1; bus.ReadAddr2 = 2'd1;
    bus.ReadUse1 = 1'b0; bus.ReadUse2 = 1'b0;
    #1;
    chk("gate_stall", 32'(bus.Stall), 0);
    bus.ReadUse2 = 1'b1;
    #1;
    chk("gate_use2_stall", 32'(bus.Stall), 1);
    bus.ReadUse2 = 1'b0;

    // overflow on r0: fourth issue holds at 3 and flags error
    do_reset();
    issue(2'd0);
    issue(2'd0);
    issue(2'd0);
    #1;
    chk("ovf_err_pre", 32'(bus.PendErr), 0);
    issue(2'd0);
    bus.ReadAddr1 = 2'd0; bus.ReadUse1 = 1'b1;
    #1;
    chk("ovf_err", 32'(bus.PendErr), 1);
    chk("ovf_stall", 32'(bus.Stall), 1);
    for (int i = 0; i < 2; i++) begin
      bus.Squash = 1'b1; bus.SquashTarget = 2'd0;
      step();
    end
    idle();
    #1;
    chk("ovf_one_left", 32'(bus.Stall), 1);
    bus.Squash = 1'b1; bus.SquashTarget = 2'd0;
    step();
    idle();
    #1;
    chk("ovf_drained", 32'(bus.Stall), 0);
    chk("ovf_err_sticky", 32'(bus.PendErr), 1);

    // reset clears error and storage; unissued write is stored but flagged
    do_reset();
    bus.ReadAddr1 = 2'd1; bus.ReadUse1 = 1'b1;
    #1;
    chk("rst2_err", 32'(bus.PendErr), 0);
    chk("rst2_rd1", 32'(bus.ReadData1), 32'h0000);
    bus.RegWrite = 1'b1; bus.RegWriteTarget = 2'd1; bus.WriteData = 16'hA5A5;
    step();
    idle();
    #1;
    chk("unf_rd1", 32'(bus.ReadData1), 32'hA5A5);
    chk("unf_err", 32'(bus.PendErr), 1);
    chk("unf_stall", 32'(bus.Stall), 0);

    // reset in the same cycle as an issue discards it
    reset = 1'b1;
    bus.Issue = 1'b1; bus.IssueTarget = 2'd2;
    step();
    reset = 1'b0;
    idle();
    bus.ReadAddr1 = 2'd2; bus.ReadUse1 = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(bus.Stall), 0);
    chk("rst_mid_err", 32'(bus.PendErr), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
- Register file at the consumer end of the writeback interface. It accepts the writeback stage's RegWrite / RegWriteTarget / WriteData triple and serves two combinational read ports to decode.
- A per-register pending-write scoreboard tracks in-flight writers. It raises Stall when decode reads a register whose value has not yet been written back.
- Sits between stage 2 (decode) and stage 5 (writeback) of the 5-stage pipeline.

Parameters:
- WORD_SIZE, 16, data width of every architectural register.
- NUM_REGS, 4, number of architectural registers; index width is 2.
- MAX_PENDING, 3, maximum in-flight writers per register (pipeline stages 3 to 5).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  writeback strobe from stage 5.
- RegWriteTarget  input  2  writeback destination index.
- WriteData  input  WORD_SIZE  writeback value.
- ReadAddr1  input  2  rs index from decode.
- ReadAddr2  input  2  rt index from decode.
- ReadUse1  input  1  decode actually consumes rs.
- ReadUse2  input  1  decode actually consumes rt.
- ReadData1  output  WORD_SIZE  rs value.
- ReadData2  output  WORD_SIZE  rt value.
- Issue  input  1  decode issues an instruction that will write a register.
- IssueTarget  input  2  its destination index.
- Squash  input  1  an in-flight writer is killed (branch flush), one per cycle.
- SquashTarget  input  2  destination index of the killed writer.
- Stall  output  1  decode must hold.
- PendErr  output  1  sticky scoreboard protocol error.

Behaviour:
- Storage: NUM_REGS x WORD_SIZE registers, one 2-bit pending counter per register (cnt[r], 0..MAX_PENDING), one PendErr flop.
- Reset, synchronous, while reset=1 at a clk edge:
  - all registers and counters go to 0; PendErr goes to 0.
  - ReadData1/2 then read 0. Stall=0 because all counters are 0. This is the reset value of every output.
  - Reset mid-operation discards all pending state, with no partial updates that cycle.
- Write: at clk edge with RegWrite=1, reg[RegWriteTarget] <= WriteData.
- Read: ReadDataN = reg[ReadAddrN] combinationally, zero latency, subject to the bypass rule under Optional Feature.
- Counter update per edge, per register r:
  - delta = +1 if (Issue and IssueTarget==r), −1 if (RegWrite and RegWriteTarget==r), −1 if (Squash and SquashTarget==r).
  - All three may hit the same r in one cycle; the net delta applies, e.g. issue+retire on the same r leaves cnt unchanged.
  - cnt+delta > MAX_PENDING: cnt holds and PendErr <= 1.
  - cnt+delta < 0: cnt holds at 0 and PendErr <= 1.
  - PendErr clears only on reset.
  - A Stall-blocked decode still presents Issue=0; decode gates Issue with ~Stall. Issue with Stall=1 is still counted.
- Busy and stall:
  - busy(r) = cnt[r] != 0, except per Optional Feature.
  - Stall = (ReadUse1 and busy(ReadAddr1)) or (ReadUse2 and busy(ReadAddr2)), purely combinational.
- RegWrite without a prior Issue (count 0) is still a legal write to storage, but it flags PendErr.
- Index 0 is an ordinary writable register (no hardwired zero).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Same-cycle writeback bypass. If RegWrite and RegWriteTarget==ReadAddrN, ReadDataN = WriteData.
  - busy(r) additionally excludes the case cnt[r]==1 and RegWrite and RegWriteTarget==r. The last pending writer retiring this cycle does not stall.
- Undefined:
  - ReadDataN always returns stored reg contents, i.e. the pre-write value in the write cycle.
  - busy(r) = cnt[r]!=0 with no exception, so the dependent instruction stalls one extra cycle.

Test Plan:
- Reset then read: reset=1 one cycle, ReadAddr1=2, ReadUse1=1 -> ReadData1=0x0000, Stall=0, PendErr=0.
- RAW stall: Issue to r1; next cycle ReadAddr1=1, ReadUse1=1 -> Stall=1. Three cycles later RegWrite r1 with 0xBEEF:
  - with WB_BYPASS_EN: Stall=0 and ReadData1=0xBEEF in that cycle.
  - without WB_BYPASS_EN: Stall=1 that cycle, then Stall=0 and ReadData1=0xBEEF next cycle.
- Simultaneous events: cnt[r2]=1; same cycle Issue r2 and RegWrite r2 with 0x1234 -> cnt[r2] stays 1, reg[r2]=0x1234, Stall remains 1 for a ReadUse of r2.
- Squash: Issue r3 twice, Squash r3 once, RegWrite r3 once -> cnt[r3]=0, Stall=0, PendErr=0.
- Overflow/underflow: Issue r0 four times with no retire -> cnt[r0]=3, PendErr=1. After reset, RegWrite r1 with cnt[r1]=0 -> reg[r1] updated, PendErr=1.
- ReadUse gating: cnt[r1]=2, ReadAddr2=1, ReadUse2=0, ReadUse1=0 -> Stall=0.
